// File: rtl/simple_alu_pkg.sv
// rtl/simple_alu_pkg.sv - shared opcode, instruction word and multiplier helper for simple_alu
package definitions;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        SHL = 3'd6,
        SHR = 3'd7
    } opcodes_t;

    typedef opcodes_t opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [15:0] a;
        logic [15:0] b;
    } instruction_t;

    // 16x16 unsigned product always fits in 32 bits, so no truncation occurs.
    function automatic logic [31:0] multiplier(input logic [15:0] a, input logic [15:0] b);
        return {16'h0000, a} * {16'h0000, b};
    endfunction

endpackage

// File: rtl/simple_alu.sv
// rtl/simple_alu.sv - registered 8-operation ALU, one instruction per cycle, 1-cycle latency
module simple_alu
    import definitions::*;
(
    input  logic         clk,
    input  logic         rst,
    input  instruction_t IW,
    output logic [31:0]  result
);

    logic [31:0] a_ext;
    logic [31:0] b_ext;
    logic [31:0] next_result;
    logic [31:0] result_q;

    assign a_ext = {16'h0000, IW.a};
    assign b_ext = {16'h0000, IW.b};

    // Shift amounts are full 16-bit values; over-range shifts naturally yield zero.
    always_comb begin
        next_result = 32'h0000_0000;
        case (IW.opcode)
            ADD:     next_result = a_ext + b_ext;
            SUB:     next_result = a_ext - b_ext;
            MUL:     next_result = multiplier(IW.a, IW.b);
            AND:     next_result = a_ext & b_ext;
            OR:      next_result = a_ext | b_ext;
            XOR:     next_result = a_ext ^ b_ext;
            SHL:     next_result = a_ext << IW.b;
            SHR:     next_result = a_ext >> IW.b;
            default: next_result = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= 32'h0000_0000;
        end else begin
            result_q <= next_result;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_simple_alu.sv
// tb/tb_simple_alu.sv - directed self-checking bench for simple_alu
module tb_simple_alu;
    import definitions::*;

    logic         clk;
    logic         rst;
    instruction_t IW;
    logic [31:0]  result;

    int vectors;
    int miscompares;

    simple_alu dut (
        .clk    (clk),
        .rst    (rst),
        .IW     (IW),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input opcodes_t op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        case (op)
            ADD: r = {16'h0, a} + {16'h0, b};
            SUB: r = {16'h0, a} - {16'h0, b};
            MUL: r = multiplier(a, b);
            AND: r = {16'h0, a & b};
            OR:  r = {16'h0, a | b};
            XOR: r = {16'h0, a ^ b};
            SHL: r = (b >= 16'd32) ? 32'h0 : ({16'h0, a} << b[4:0]);
            SHR: r = (b >= 16'd16) ? 32'h0 : ({16'h0, a} >> b[3:0]);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] expected);
        vectors++;
        assert (result === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, result, expected);
        end
    endtask

    task automatic apply(input string tag, input opcodes_t op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] expected);
        @(negedge clk);
        IW = '{opcode: op, a: a, b: b};
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    initial begin
        logic [31:0] sweep_exp [8];
        opcodes_t    op;
        logic [15:0] ra, rb;

        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        IW = '{opcode: MUL, a: 16'h1234, b: 16'h5678};

        #1 rst = 1'b1;
        #1 check("reset_async", 32'h0);
        repeat (3) @(posedge clk);
        #1 check("reset_held", 32'h0);

        @(negedge clk);
        IW = '{opcode: ADD, a: 16'd16, b: 16'd2};
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_capture", 32'd18);

        sweep_exp = '{32'd18, 32'd14, 32'd32, 32'd0, 32'd18, 32'd18, 32'd64, 32'd4};
        for (int i = 0; i < 8; i++) begin
            op = opcodes_t'(i);
            apply($sformatf("sweep_%s", op.name()), op, 16'd16, 16'd2, sweep_exp[i]);
        end

        apply("sub_wrap", SUB, 16'd2,    16'd16,   32'hFFFF_FFF2);
        apply("mul_max",  MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        apply("add_max",  ADD, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE);

        apply("shl_16",   SHL, 16'hFFFF, 16'd16, 32'hFFFF_0000);
        apply("shl_31",   SHL, 16'd1,    16'd31, 32'h8000_0000);
        apply("shl_40",   SHL, 16'd1,    16'd40, 32'h0);
        apply("shr_15",   SHR, 16'h8000, 16'd15, 32'h1);
        apply("shr_16",   SHR, 16'h8000, 16'd16, 32'h0);

        // Holding the instruction keeps the result constant.
        @(posedge clk);
        #1 check("hold", 32'h0);

        for (int i = 0; i < 24; i++) begin
            op = opcodes_t'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = (op == SHL || op == SHR) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            apply($sformatf("rand_%0d", i), op, ra, rb, model(op, ra, rb));
        end

        // Mid-stream reset pulsed between edges.
        @(negedge clk);
        IW = '{opcode: MUL, a: 16'd300, b: 16'd7};
        @(posedge clk);
        #1 check("pre_reset", 32'd2100);
        #2 rst = 1'b1;
        #1 check("mid_reset_async", 32'h0);
        @(posedge clk);
        #1 check("mid_reset_held", 32'h0);
        @(negedge clk);
        rst = 1'b0;
        IW = '{opcode: XOR, a: 16'hF0F0, b: 16'h0FF0};
        @(posedge clk);
        #1 check("post_reset", 32'h0000_FF00);

        for (int i = 0; i < 8; i++) begin
            op = opcodes_t'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 20));
            apply($sformatf("rand_post_%0d", i), op, ra, rb, model(op, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
